// File: rtl/imem_arbiter.sv
// rtl/imem_arbiter.sv - round-robin arbiter sharing one instruction RAM between fetch and loader
// Loader may hold the RAM with ld_lock, bounded by MAX_LOCK so a pending fetch is never starved.
module imem_arbiter #(
  parameter int ADDR_W   = 10,
  parameter int MAX_LOCK = 8
) (
  input  logic              clk,
  input  logic              rst_n,

  input  logic              if_req_valid,
  output logic              if_req_ready,
  input  logic [31:0]       if_addr,
  output logic              if_rsp_valid,
  output logic [31:0]       if_rsp_data,

  input  logic              ld_req_valid,
  output logic              ld_req_ready,
  input  logic              ld_we,
  input  logic [31:0]       ld_addr,
  input  logic [31:0]       ld_wdata,
  input  logic              ld_lock,
  output logic              ld_rsp_valid,
  output logic [31:0]       ld_rsp_data,

  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata
);

  typedef enum logic [1:0] {
    LAST_IF = 2'd0,
    LAST_LD = 2'd1,
    LOCKED  = 2'd2
  } last_e;

  last_e       r_last;
  last_e       w_last_nxt;
  logic [7:0]  r_lock_cnt;
  logic [7:0]  w_lock_cnt_nxt;
  logic        r_rsp_if;
  logic        r_rsp_ld;
  logic        w_gnt_if;
  logic        w_gnt_ld;
  logic        w_lock_ok;
  logic        w_unused;

  localparam logic [7:0] MAX_LOCK_C = 8'(MAX_LOCK);

  // Grants are gated by rst_n so every request-side output drops asynchronously in reset.
  always_comb begin
    w_gnt_if       = 1'b0;
    w_gnt_ld       = 1'b0;
    w_last_nxt     = r_last;
    w_lock_cnt_nxt = r_lock_cnt;
    w_lock_ok      = ld_lock && (r_lock_cnt < MAX_LOCK_C);

    if (rst_n) begin
      if (if_req_valid && ld_req_valid) begin
        case (r_last)
          LAST_IF: w_gnt_ld = 1'b1;
          LAST_LD: w_gnt_if = 1'b1;
          LOCKED: begin
            if (w_lock_ok) w_gnt_ld = 1'b1;
            else           w_gnt_if = 1'b1;
          end
          default: w_gnt_if = 1'b1;
        endcase
      end else if (if_req_valid) begin
        w_gnt_if = 1'b1;
      end else if (ld_req_valid) begin
        w_gnt_ld = 1'b1;
      end
    end

    // Every locked loader grant counts, including the one that enters LOCKED.
    if (w_gnt_if) begin
      w_last_nxt     = LAST_IF;
      w_lock_cnt_nxt = 8'd0;
    end else if (w_gnt_ld) begin
      if (ld_lock) begin
        w_last_nxt     = LOCKED;
        w_lock_cnt_nxt = (r_lock_cnt == 8'hFF) ? r_lock_cnt : r_lock_cnt + 8'd1;
      end else begin
        w_last_nxt     = LAST_LD;
        w_lock_cnt_nxt = 8'd0;
      end
    end else if (!ld_lock) begin
      w_lock_cnt_nxt = 8'd0;
      if (r_last == LOCKED) w_last_nxt = LAST_LD;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_last     <= LAST_LD;
      r_lock_cnt <= 8'd0;
      r_rsp_if   <= 1'b0;
      r_rsp_ld   <= 1'b0;
    end else begin
      r_last     <= w_last_nxt;
      r_lock_cnt <= w_lock_cnt_nxt;
      r_rsp_if   <= w_gnt_if;
      r_rsp_ld   <= w_gnt_ld && !ld_we;
    end
  end

  assign if_req_ready = w_gnt_if;
  assign ld_req_ready = w_gnt_ld;

  assign mem_en    = w_gnt_if || w_gnt_ld;
  assign mem_we    = w_gnt_ld && ld_we;
  assign mem_addr  = w_gnt_ld ? ld_addr[ADDR_W+1:2] :
                     w_gnt_if ? if_addr[ADDR_W+1:2] : '0;
  assign mem_wdata = mem_en ? ld_wdata : 32'd0;

  assign if_rsp_valid = r_rsp_if;
  assign ld_rsp_valid = r_rsp_ld;
  assign if_rsp_data  = r_rsp_if ? mem_rdata : 32'd0;
  assign ld_rsp_data  = r_rsp_ld ? mem_rdata : 32'd0;

  // Byte-offset and above-range address bits are dropped on purpose (addresses wrap).
  assign w_unused = ^{if_addr[31:ADDR_W+2], if_addr[1:0], ld_addr[31:ADDR_W+2], ld_addr[1:0]};

endmodule

// File: tb/tb_imem_arbiter.sv
// tb/tb_imem_arbiter.sv - directed self-checking bench for imem_arbiter
module tb_imem_arbiter;
  localparam int ADDR_W   = 10;
  localparam int MAX_LOCK = 8;

  localparam logic [31:0] WA = 32'hA0A0_0001;
  localparam logic [31:0] WB = 32'hB0B0_0002;
  localparam logic [31:0] WC = 32'hC0C0_0003;
  localparam logic [31:0] WL = 32'h1111_2222;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              rst_n;
  logic              if_req_valid, if_req_ready, if_rsp_valid;
  logic [31:0]       if_addr, if_rsp_data;
  logic              ld_req_valid, ld_req_ready, ld_we, ld_lock, ld_rsp_valid;
  logic [31:0]       ld_addr, ld_wdata, ld_rsp_data;
  logic              mem_en, mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_wdata, mem_rdata;

  imem_arbiter #(.ADDR_W(ADDR_W), .MAX_LOCK(MAX_LOCK)) dut (
    .clk(clk), .rst_n(rst_n),
    .if_req_valid(if_req_valid), .if_req_ready(if_req_ready), .if_addr(if_addr),
    .if_rsp_valid(if_rsp_valid), .if_rsp_data(if_rsp_data),
    .ld_req_valid(ld_req_valid), .ld_req_ready(ld_req_ready), .ld_we(ld_we),
    .ld_addr(ld_addr), .ld_wdata(ld_wdata), .ld_lock(ld_lock),
    .ld_rsp_valid(ld_rsp_valid), .ld_rsp_data(ld_rsp_data),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  // Synchronous-read RAM model
  logic [31:0] ram [0:(1<<ADDR_W)-1];
  always @(posedge clk) begin
    if (mem_en) begin
      if (mem_we) ram[mem_addr] <= mem_wdata;
      else        mem_rdata     <= ram[mem_addr];
    end
  end

  int n_total = 0;
  int n_bad   = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic idle_in();
    if_req_valid = 1'b0; if_addr  = 32'd0;
    ld_req_valid = 1'b0; ld_we    = 1'b0; ld_addr = 32'd0;
    ld_wdata     = 32'd0; ld_lock = 1'b0;
  endtask

  task automatic next_cyc();
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0; #2; rst_n = 1'b1;
  endtask

  task automatic ld_wr(input logic [31:0] a, input logic [31:0] d);
    idle_in();
    ld_req_valid = 1'b1; ld_we = 1'b1; ld_addr = a; ld_wdata = d;
    @(negedge clk);
    chk("ld_wr_ready", {31'd0, ld_req_ready}, 32'd1);
    next_cyc();
    idle_in();
  endtask

  logic [31:0] exp_word [0:2];
  logic        exp_if, prev_if;

  initial begin
    idle_in();
    rst_n = 1'b0;
    if_req_valid = 1'b1; ld_req_valid = 1'b1;
    #12;
    chk("rst_if_ready", {31'd0, if_req_ready}, 32'd0);
    chk("rst_ld_ready", {31'd0, ld_req_ready}, 32'd0);
    chk("rst_mem_en",   {31'd0, mem_en},       32'd0);
    chk("rst_mem_we",   {31'd0, mem_we},       32'd0);
    chk("rst_if_rspv",  {31'd0, if_rsp_valid}, 32'd0);
    chk("rst_ld_rspv",  {31'd0, ld_rsp_valid}, 32'd0);
    chk("rst_if_data",  if_rsp_data, 32'd0);
    chk("rst_ld_data",  ld_rsp_data, 32'd0);
    idle_in();
    next_cyc();
    rst_n = 1'b1;
    next_cyc();

    ld_wr(32'h0, WA);
    ld_wr(32'h4, WB);
    ld_wr(32'h8, WC);
    ld_wr(32'h20, WL);

    // Fetch-only back-to-back reads
    exp_word[0] = WA; exp_word[1] = WB; exp_word[2] = WC;
    for (int i = 0; i < 3; i++) begin
      if_req_valid = 1'b1; if_addr = 32'(i * 4);
      @(negedge clk);
      chk("f_ready", {31'd0, if_req_ready}, 32'd1);
      chk("f_addr",  {22'd0, mem_addr}, 32'(i));
      if (i == 0) chk("f_no_ld_rsp_after_wr", {31'd0, ld_rsp_valid}, 32'd0);
      else begin
        chk("f_rspv", {31'd0, if_rsp_valid}, 32'd1);
        chk("f_data", if_rsp_data, exp_word[i-1]);
      end
      next_cyc();
    end
    idle_in();
    @(negedge clk);
    chk("f_rspv_last", {31'd0, if_rsp_valid}, 32'd1);
    chk("f_data_last", if_rsp_data, WC);
    next_cyc();

    // Both valid, no lock: alternate IF, LD starting with IF after reset
    do_reset();
    if_req_valid = 1'b1; if_addr = 32'h0;
    ld_req_valid = 1'b1; ld_addr = 32'h20; ld_we = 1'b0; ld_lock = 1'b0;
    prev_if = 1'b0;
    for (int c = 0; c < 8; c++) begin
      exp_if = (c % 2 == 0);
      @(negedge clk);
      chk("rr_if_ready", {31'd0, if_req_ready}, {31'd0, exp_if});
      chk("rr_ld_ready", {31'd0, ld_req_ready}, {31'd0, !exp_if});
      if (c > 0) begin
        chk("rr_if_rspv", {31'd0, if_rsp_valid}, {31'd0, prev_if});
        chk("rr_ld_rspv", {31'd0, ld_rsp_valid}, {31'd0, !prev_if});
        if (prev_if) chk("rr_if_data", if_rsp_data, WA);
        else         chk("rr_ld_data", ld_rsp_data, WL);
      end
      prev_if = exp_if;
      next_cyc();
    end
    idle_in();
    next_cyc();

    // Loader write then fetch read of the same word
    ld_req_valid = 1'b1; ld_we = 1'b1; ld_addr = 32'h10; ld_wdata = 32'hDEAD_BEEF;
    @(negedge clk);
    chk("wr_ready", {31'd0, ld_req_ready}, 32'd1);
    chk("wr_we",    {31'd0, mem_we}, 32'd1);
    chk("wr_addr",  {22'd0, mem_addr}, 32'd4);
    chk("wr_wdata", mem_wdata, 32'hDEAD_BEEF);
    next_cyc();
    idle_in();
    if_req_valid = 1'b1; if_addr = 32'h10;
    @(negedge clk);
    chk("wr_no_ld_rsp", {31'd0, ld_rsp_valid}, 32'd0);
    chk("rd_ready",     {31'd0, if_req_ready}, 32'd1);
    next_cyc();
    idle_in();
    @(negedge clk);
    chk("rd_rspv", {31'd0, if_rsp_valid}, 32'd1);
    chk("rd_data", if_rsp_data, 32'hDEAD_BEEF);
    chk("rd_no_ld_rsp", {31'd0, ld_rsp_valid}, 32'd0);
    next_cyc();

    // Locked loader: IF first after reset, then 8 LD / 1 IF repeating
    do_reset();
    if_req_valid = 1'b1; if_addr = 32'h0;
    ld_req_valid = 1'b1; ld_addr = 32'h20; ld_we = 1'b0; ld_lock = 1'b1;
    for (int c = 0; c < 20; c++) begin
      exp_if = (c == 0) ? 1'b1 : (((c - 1) % 9) == 8);
      @(negedge clk);
      chk("lk_if_ready", {31'd0, if_req_ready}, {31'd0, exp_if});
      chk("lk_ld_ready", {31'd0, ld_req_ready}, {31'd0, !exp_if});
      next_cyc();
    end
    ld_lock = 1'b0;
    @(negedge clk);
    chk("unlock_if_wins", {31'd0, if_req_ready}, 32'd1);
    next_cyc();
    idle_in();
    next_cyc();

    // Address wrap and ignored byte offset
    if_req_valid = 1'b1; if_addr = 32'h1004;
    @(negedge clk);
    chk("wrap_addr", {22'd0, mem_addr}, 32'd1);
    next_cyc();
    if_addr = 32'h7;
    @(negedge clk);
    chk("wrap_data", if_rsp_data, WB);
    chk("off_addr",  {22'd0, mem_addr}, 32'd1);
    next_cyc();
    idle_in();
    @(negedge clk);
    chk("off_data", if_rsp_data, WB);
    next_cyc();

    // Reset during a granted fetch: grant killed, no response afterwards
    if_req_valid = 1'b1; if_addr = 32'h0;
    @(negedge clk);
    chk("mr_ready_pre", {31'd0, if_req_ready}, 32'd1);
    #1 rst_n = 1'b0;
    #1;
    chk("mr_ready_async", {31'd0, if_req_ready}, 32'd0);
    chk("mr_mem_en",      {31'd0, mem_en}, 32'd0);
    next_cyc();
    idle_in();
    rst_n = 1'b1;
    @(negedge clk);
    chk("mr_if_rspv", {31'd0, if_rsp_valid}, 32'd0);
    chk("mr_ld_rspv", {31'd0, ld_rsp_valid}, 32'd0);
    next_cyc();

    // Reset just after an accepted fetch: pending response dropped
    if_req_valid = 1'b1; if_addr = 32'h0;
    next_cyc();
    idle_in();
    chk("pr_rspv_up", {31'd0, if_rsp_valid}, 32'd1);
    rst_n = 1'b0;
    #1;
    chk("pr_rspv_dropped", {31'd0, if_rsp_valid}, 32'd0);
    chk("pr_data_zero",    if_rsp_data, 32'd0);
    #2 rst_n = 1'b1;
    @(negedge clk);
    chk("pr_rspv_after", {31'd0, if_rsp_valid}, 32'd0);
    next_cyc();

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
